// File: rtl/plank_pkg.sv
// plank_pkg: shared types and constants for the plank polling logic
package plank_pkg;
  localparam int PLANK_IDX_W = 3;
  localparam logic [7:0] HDR = 8'hAA;
  localparam logic [7:0] FTR = 8'h55;
  localparam logic [7:0] ACK = 8'hEE;
  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT_RSP, GAP, RST_PLANK, DONE} poll_state_t;
endpackage

// File: rtl/poll_timer.sv
// poll_timer: loadable saturating down-counter, tc_o high while the count is zero
//   clk_i/rst_ni clock and async active-low reset; load_i/val_i reload; tc_o terminal count
module poll_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/plank_poll_scheduler.sv
// plank_poll_scheduler: walks enabled planks, polls each, retries, resets dead planks
//   i_start/i_plank_mask start a cycle; o_poll_valid/o_poll_idx/i_poll_ready request handshake
//   i_rsp_valid/i_rsp_idx/i_rsp_ok responses; o_busy/o_done cycle status
//   o_alive/o_timeout per-plank status; o_reset_plank per-plank reset pulse
module plank_poll_scheduler
  import plank_pkg::*;
#(
  parameter int NUM_PLANKS  = 8,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int GAP_CYC     = 10_000,
  parameter int RETRY_MAX   = 2,
  parameter int RESET_CYC   = 1_000
) (
  input  logic                   i_clk_100,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [NUM_PLANKS-1:0]  i_plank_mask,
  output logic                   o_poll_valid,
  output logic [PLANK_IDX_W-1:0] o_poll_idx,
  input  logic                   i_poll_ready,
  input  logic                   i_rsp_valid,
  input  logic [PLANK_IDX_W-1:0] i_rsp_idx,
  input  logic                   i_rsp_ok,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [NUM_PLANKS-1:0]  o_alive,
  output logic [NUM_PLANKS-1:0]  o_timeout,
  output logic [NUM_PLANKS-1:0]  o_reset_plank
);
  localparam int TMAX = TIMEOUT_CYC > GAP_CYC ? (TIMEOUT_CYC > RESET_CYC ? TIMEOUT_CYC : RESET_CYC)
                                              : (GAP_CYC > RESET_CYC ? GAP_CYC : RESET_CYC);
  localparam int TW = $clog2(TMAX) + 1;
  localparam int PW = $clog2(NUM_PLANKS) + 1;
  localparam int AW = $clog2(RETRY_MAX) + 1;
  poll_state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] att_q, att_d;
  logic [NUM_PLANKS-1:0] mask_q, mask_d, alive_q, alive_d, tout_q, tout_d, sel, rem;
  logic tmr_load, tmr_tc, hit;
  logic [TW-1:0] tmr_val;
  // rem holds the enabled planks at and above ptr; empty means the cycle is finished
  assign sel = NUM_PLANKS'(1) << ptr_q;
  assign rem = mask_q >> ptr_q;
  assign hit = i_rsp_valid && (PW'(i_rsp_idx) == ptr_q);
  poll_timer #(.W(TW)) u_tmr (
    .clk_i (i_clk_100),
    .rst_ni(i_rst_n),
    .load_i(tmr_load),
    .val_i (tmr_val),
    .tc_o  (tmr_tc)
  );
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    att_d    = att_q;
    mask_d   = mask_q;
    alive_d  = alive_q;
    tout_d   = tout_q;
    tmr_load = 1'b0;
    tmr_val  = TW'(TIMEOUT_CYC - 1);
    case (state_q)
      IDLE: if (i_start) begin
        mask_d  = i_plank_mask;
        ptr_d   = '0;
        att_d   = '0;
        state_d = SELECT;
      end
      SELECT: begin
        state_d = rem == '0 ? DONE : rem[0] ? ISSUE : SELECT;
        ptr_d   = (rem != '0 && !rem[0]) ? ptr_q + 1'b1 : ptr_q;
      end
      ISSUE: if (i_poll_ready) begin
        tmr_load = 1'b1;
        state_d  = WAIT_RSP;
      end
      WAIT_RSP:
        if (hit && i_rsp_ok) begin
          alive_d  = alive_q | sel;
          tout_d   = tout_q & ~sel;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYC - 1);
          state_d  = GAP;
        end else if (hit || tmr_tc) begin
          if (att_q < AW'(RETRY_MAX)) begin
            att_d   = att_q + 1'b1;
            state_d = ISSUE;
          end else begin
            alive_d  = alive_q & ~sel;
            tout_d   = tout_q | sel;
            tmr_load = 1'b1;
            tmr_val  = TW'(RESET_CYC - 1);
            state_d  = RST_PLANK;
          end
        end
      RST_PLANK: if (tmr_tc) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(GAP_CYC - 1);
        state_d  = GAP;
      end
      GAP: if (tmr_tc) begin
        ptr_d   = ptr_q + 1'b1;
        att_d   = '0;
        state_d = SELECT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk_100 or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      att_q   <= '0;
      mask_q  <= '0;
      alive_q <= '0;
      tout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      att_q   <= att_d;
      mask_q  <= mask_d;
      alive_q <= alive_d;
      tout_q  <= tout_d;
    end
  assign o_poll_valid  = (state_q == ISSUE);
  assign o_poll_idx    = ptr_q[PLANK_IDX_W-1:0];
  assign o_busy        = (state_q != IDLE) && (state_q != DONE);
  assign o_done        = (state_q == DONE);
  assign o_alive       = alive_q;
  assign o_timeout     = tout_q;
  assign o_reset_plank = (state_q == RST_PLANK) ? sel : '0;
endmodule

// File: tb/tb_plank_poll_scheduler.sv
// tb_plank_poll_scheduler: vector table plus scoreboarded poll requests for plank_poll_scheduler
module tb_plank_poll_scheduler;
  localparam int TO = 100;
  localparam int GP = 20;
  localparam int RC = 10;
  logic clk = 0, rst_n = 0, start = 0, poll_ready = 1, rsp_valid = 0, rsp_ok = 0;
  logic [7:0] mask = 0;
  logic [2:0] rsp_idx = 0;
  logic poll_valid, busy, done;
  logic [2:0] poll_idx;
  logic [7:0] alive, tout, rst_pl;
  always #5 clk = ~clk;
  plank_poll_scheduler #(.NUM_PLANKS(8), .TIMEOUT_CYC(TO), .GAP_CYC(GP), .RETRY_MAX(2), .RESET_CYC(RC)) dut (
    .i_clk_100(clk), .i_rst_n(rst_n), .i_start(start), .i_plank_mask(mask),
    .o_poll_valid(poll_valid), .o_poll_idx(poll_idx), .i_poll_ready(poll_ready),
    .i_rsp_valid(rsp_valid), .i_rsp_idx(rsp_idx), .i_rsp_ok(rsp_ok),
    .o_busy(busy), .o_done(done), .o_alive(alive), .o_timeout(tout), .o_reset_plank(rst_pl)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // plank behaviour: 0 OK after 50, 1 silent, 2 bad once then OK, 3 silent but stray idx5 reply, 4 OK on timeout terminal cycle
  typedef struct {
    logic [7:0]  mask;
    logic [23:0] modes;
    logic [7:0]  alive;
    logic [7:0]  tout;
    logic [7:0]  rst;
    int          nrst;
  } vec_t;
  vec_t v[6];
  int mode_a[8], att_a[8], last_hs[8];
  int exp_q[$];
  int cyc = 0, nrst = 0, rst_cycles = 0;
  logic [7:0] rst_or = 0, rst_prev = 0;
  initial begin
    int cd, ci, i;
    bit cok;
    cd = 0; ci = 0; cok = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      rsp_valid = 0;
      if (!rst_n) cd = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rsp_valid = 1;
          rsp_idx = ci[2:0];
          rsp_ok = cok;
        end
      end
      if (rst_pl != 0) begin
        rst_cycles++;
        chk("rst_onehot", 32'($onehot(rst_pl)), 1);
        if (rst_prev == 0) nrst++;
        rst_or |= rst_pl;
      end
      rst_prev = rst_pl;
      if (poll_valid && poll_ready) begin
        i = int'(poll_idx);
        if (exp_q.size() == 0) chk("poll_unexpected", i, 32'hFF);
        else chk("poll_idx", i, exp_q.pop_front());
        if ((mode_a[i] == 1 || mode_a[i] == 3) && att_a[i] > 0) chk("retry_spacing", cyc - last_hs[i], TO + 1);
        last_hs[i] = cyc;
        att_a[i]++;
        case (mode_a[i])
          0: begin cd = 50; ci = i; cok = 1; end
          1: cd = 0;
          2: begin cd = 50; ci = i; cok = (att_a[i] > 1); end
          3: begin cd = 30; ci = 5; cok = 1; end
          default: begin cd = TO; ci = i; cok = 1; end
        endcase
      end
    end
  end
  task automatic load_modes(input logic [7:0] m, input logic [23:0] modes);
    logic [23:0] mv;
    mv = modes;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      mode_a[i] = int'(mv[3*i+:3]);
      att_a[i] = 0;
      if (m[i]) repeat ((mode_a[i] == 1 || mode_a[i] == 3) ? 3 : (mode_a[i] == 2 ? 2 : 1)) exp_q.push_back(i);
    end
    nrst = 0; rst_or = 0; rst_cycles = 0;
  endtask
  task automatic wait_done(output bit seen);
    int n;
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    seen = done;
  endtask
  initial begin
    bit seen;
    int n;
    v[0] = '{8'hFF, 24'h000000, 8'hFF, 8'h00, 8'h00, 0};
    v[1] = '{8'hFF, 24'h000200, 8'hF7, 8'h08, 8'h08, 1};
    v[2] = '{8'h05, 24'h000000, 8'hF7, 8'h08, 8'h00, 0};
    v[3] = '{8'h02, 24'h000010, 8'hF7, 8'h08, 8'h00, 0};
    v[4] = '{8'h04, 24'h0000C0, 8'hF3, 8'h0C, 8'h04, 1};
    v[5] = '{8'h08, 24'h000800, 8'hFB, 8'h04, 8'h00, 0};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {poll_valid, busy, done, poll_idx, alive, tout, rst_pl}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      load_modes(v[k].mask, v[k].modes);
      start = 1; mask = v[k].mask;
      @(negedge clk);
      start = 0; mask = 8'h00;
      chk("busy_after_start", {busy, poll_valid}, 2'b10);
      @(negedge clk);
      if (k == 0) chk("first_poll_latency", {poll_valid, poll_idx}, 4'b1000);
      repeat (8) @(negedge clk);
      start = 1; mask = 8'h00;
      @(negedge clk);
      start = 0;
      wait_done(seen);
      chk("done_seen", seen, 1);
      chk("busy_at_done", busy, 0);
      @(negedge clk);
      chk("done_single", done, 0);
      chk("alive", alive, v[k].alive);
      chk("timeout", tout, v[k].tout);
      chk("reset_bits", rst_or, v[k].rst);
      chk("reset_pulses", nrst, v[k].nrst);
      chk("reset_width", rst_cycles, RC * v[k].nrst);
      chk("polls_left", exp_q.size(), 0);
      repeat (3) @(negedge clk);
    end
    // all-zero mask
    start = 1; mask = 8'h00;
    @(negedge clk);
    start = 0;
    chk("mask0_c1", {busy, done}, 2'b10);
    @(negedge clk);
    chk("mask0_c2", {busy, done, poll_valid}, 3'b010);
    repeat (2) @(negedge clk);
    // request held while ready is low
    load_modes(8'h01, 24'h0);
    poll_ready = 0;
    start = 1; mask = 8'h01;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("valid_held", {poll_valid, poll_idx}, 4'b1000);
    poll_ready = 1;
    wait_done(seen);
    chk("ready_done", seen, 1);
    chk("ready_polls_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    // reset asserted during the plank reset pulse
    load_modes(8'h08, 24'h000200);
    start = 1; mask = 8'h08;
    @(negedge clk);
    start = 0;
    n = 0;
    while (rst_pl == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_pulse_seen", rst_pl, 8'h08);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_reset", {poll_valid, busy, done, alive, tout, rst_pl}, 0);
    @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {busy, rst_pl}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
